mod_time_counter: RTL and testbench
===================================

MOD_TIME_COUNTER -- requirements
Module: mod_time_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 60: count range 0..MODULUS-1, legal range 2..1024.
REQ-002 SHALL have parameter WIDTH, default $clog2(MODULUS): value/load width.
REQ-003 SHALL have parameter RESET_VALUE, default 0: value after reset, legal range < MODULUS.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_all, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cnt_en, input, 1: carry-in from the lower stage; one step per cycle high.
REQ-007 SHALL have port up_dn, input, 1: 1 = count up, 0 = count down.
REQ-008 SHALL have port set_mode, input, 1: 1 = SET state (manual adjust), 0 = RUN state.
REQ-009 SHALL have port adj_step, input, 1: manual step pulse; honoured in SET only.
REQ-010 SHALL have port load, input, 1: synchronous load strobe.
REQ-011 SHALL have port load_val, input, WIDTH: value to load.
REQ-012 SHALL have port value, output, WIDTH: current count.
REQ-013 SHALL have port carry_out, output, 1: one-cycle wrap pulse, up or down, feeding the next stage's cnt_en.
REQ-014 SHALL have port at_term, output, 1: combinational; high when value is MODULUS-1 (up) or 0 (down).
REQ-015 SHALL have port load_err, output, 1: one-cycle pulse when load_val >= MODULUS.

Function
REQ-016 SHALL use the same clk as every other stage; cnt_en SHALL be a level enable and never a clock.
REQ-017 SHALL have a two-state FSM: RUN and SET, with transitions on the registered set_mode; the state change takes effect the cycle after set_mode changes.
REQ-018 In RUN, when cnt_en is high, SHALL step value by +1 if up_dn=1 and -1 if up_dn=0; adj_step is ignored.
REQ-019 In SET, cnt_en SHALL be ignored; a rising edge of adj_step (edge-detected internally) SHALL step value one place in the up_dn direction.
REQ-020 Up wrap SHALL take MODULUS-1 to 0; down wrap SHALL take 0 to MODULUS-1; value SHALL never leave 0..MODULUS-1.
REQ-021 carry_out SHALL be registered and high for exactly the one cycle following the edge at which a RUN wrap occurred; latency is one cycle from the cnt_en sample.
REQ-022 SET-mode wraps SHALL NOT assert carry_out, so adjustment does not ripple into higher stages.
REQ-023 When load_val < MODULUS, load SHALL set value = load_val at the next edge, with no carry_out.
REQ-024 When load_val >= MODULUS, load SHALL leave value unchanged and pulse load_err for one cycle.
REQ-025 Priority SHALL be: reset_all > load > step (cnt_en or adj_step); when load and cnt_en coincide, the step is discarded.
REQ-026 up_dn changing in the same cycle as cnt_en SHALL use the newly sampled up_dn.
REQ-027 All arithmetic SHALL be done in WIDTH+1 bits and SHALL have no overflow dependence on power-of-two MODULUS.

Reset
REQ-028 While reset_all is high at an edge: value = RESET_VALUE, carry_out = 0, load_err = 0, FSM = RUN, adj_step edge register = 0.
REQ-029 Reset mid-count or mid-SET SHALL abort the operation; no carry_out SHALL follow reset release.
REQ-030 The first step SHALL be accepted on the first edge after reset_all is deasserted.

Structure
REQ-031 The shared package clock_pkg SHALL hold the typedef enum {RUN, SET} cnt_mode_t and the constants SEC_MODULUS=60, MIN_MODULUS=60, HOUR_MODULUS=24.
REQ-032 SHALL have one sub-module, mod_step: combinational next-value/wrap calculation (inputs value, up_dn; outputs next, wrap), shared by the RUN and SET paths.
REQ-033 SHALL have an elaboration-time check that MODULUS >= 2 and RESET_VALUE < MODULUS.

Verification
REQ-034 MODULUS=60, RUN, up, cnt_en held high from 0 -> 59 followed by 0; carry_out is high exactly one cycle after the 59->0 edge, once per 60 cycles.
REQ-035 MODULUS=24, RUN, down from 0 with a one-cycle cnt_en -> value 23 and carry_out pulsed once.
REQ-036 SET mode, value 59, three adj_step pulses up -> 0, 1, 2; carry_out stays 0; cnt_en pulses meanwhile are ignored.
REQ-037 load with load_val=45 and cnt_en high in the same cycle -> value 45, no carry; load_val=60 -> value unchanged and load_err pulses once.
REQ-038 reset_all asserted at value 59 with cnt_en high -> value 0, carry_out 0 on that edge and the following edge.
REQ-039 Chain of two instances (60, 24), cnt_en tied high on the low stage -> high stage increments every 60 cycles and wraps 23->0 after 1440 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock counter stages: mode type and stage moduli.
package clock_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } cnt_mode_t;

    localparam int SEC_MODULUS  = 60;
    localparam int MIN_MODULUS  = 60;
    localparam int HOUR_MODULUS = 24;

endpackage : clock_pkg

// File: rtl/mod_step.sv
// Combinational modulo step: next value one place up or down, with wrap flag.
// Arithmetic is carried out one bit wider than the value, so it works for any modulus.
module mod_step #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic [WIDTH-1:0] value,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_W = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;

    // Up wraps when the increment reaches MODULUS; down wraps on borrow out of zero.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next  = '0;
        wrap  = 1'b0;
        inc_w = {1'b0, value} + (WIDTH+1)'(1);
        dec_w = {1'b0, value} - (WIDTH+1)'(1);
        if (up_dn) begin
            if (inc_w >= MOD_W) begin
                next = '0;
                wrap = 1'b1;
            end else begin
                next = inc_w[WIDTH-1:0];
            end
        end else begin
            if (dec_w[WIDTH]) begin
                next = TOP_W;
                wrap = 1'b1;
            end else begin
                next = dec_w[WIDTH-1:0];
            end
        end
    end

endmodule : mod_step

// File: rtl/mod_time_counter.sv
// One cascadable stage of a clock counter (seconds, minutes or hours).
// RUN: steps on cnt_en and emits a registered carry on wrap.
// SET: steps on adj_step rising edges, never carries.
module mod_time_counter
    import clock_pkg::*;
#(
    parameter int MODULUS     = 60,
    parameter int WIDTH       = $clog2(MODULUS),
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset_all,
    input  logic             cnt_en,
    input  logic             up_dn,
    input  logic             set_mode,
    input  logic             adj_step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             carry_out,
    output logic             at_term,
    output logic             load_err
);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_W   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

    // Reject illegal parameterisations at elaboration.
    if (MODULUS < 2 || MODULUS > 1024 || RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_param_check
        $error("mod_time_counter: need 2 <= MODULUS <= 1024 and 0 <= RESET_VALUE < MODULUS");
    end

    cnt_mode_t        mode_q, mode_d;
    logic             adj_q, adj_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;

    logic             run_step;
    logic             set_step;
    logic             load_ok;
    logic [WIDTH-1:0] step_next;
    logic             step_wrap;

    mod_step #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_step (
        .value (value_q),
        .up_dn (up_dn),
        .next  (step_next),
        .wrap  (step_wrap)
    );

    // Mode state register; reset returns the stage to RUN.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block ordering.
        if (reset_all) begin
            mode_q <= RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode simply follows the registered set_mode level.
    always_comb begin
        mode_d = set_mode ? SET : RUN;
    end

    // Mode-dependent step qualification: cnt_en in RUN, adj_step rising edge in SET.
    always_comb begin
        run_step = (mode_q == RUN) && cnt_en;
        set_step = (mode_q == SET) && adj_step && !adj_q;
    end

    // Datapath next state: load beats step; only RUN wraps produce a carry.
    always_comb begin
        load_ok    = ({1'b0, load_val} < MOD_W);
        value_d    = value_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        adj_d      = adj_step;
        if (load) begin
            if (load_ok) begin
                value_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (run_step || set_step) begin
            value_d = step_next;
            carry_d = run_step && step_wrap;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_all) begin
            value_q    <= RESET_W;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
            adj_q      <= 1'b0;
        end else begin
            value_q    <= value_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
            adj_q      <= adj_d;
        end
    end

    // Terminal-count flag tracks the live up_dn direction.
    always_comb begin
        at_term = up_dn ? (value_q == TOP_W) : (value_q == '0);
    end

    assign value     = value_q;
    assign carry_out = carry_q;
    assign load_err  = load_err_q;

endmodule : mod_time_counter

// File: tb/tb_mod_time_counter.sv
// Bench for mod_time_counter: behavioural model on the MODULUS=60 stage,
// a standalone MODULUS=24 stage, and a 60->24 cascade.
module tb_mod_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- MODULUS=60 stage under the model ----------------
    logic       rst = 1'b1, cen = 1'b0, ud = 1'b0, sm = 1'b0, adj = 1'b0, ld = 1'b0;
    logic [5:0] lv = '0;
    logic [5:0] val0;
    logic       co0, at0, le0;

    mod_time_counter #(.MODULUS(60)) dut0 (
        .clk(clk), .reset_all(rst), .cnt_en(cen), .up_dn(ud), .set_mode(sm),
        .adj_step(adj), .load(ld), .load_val(lv),
        .value(val0), .carry_out(co0), .at_term(at0), .load_err(le0)
    );

    // ---------------- MODULUS=24 stage ----------------
    logic       rst24 = 1'b1, cen24 = 1'b0, ud24 = 1'b0;
    logic [4:0] val24;
    logic       co24, at24, le24;

    mod_time_counter #(.MODULUS(24)) dut24 (
        .clk(clk), .reset_all(rst24), .cnt_en(cen24), .up_dn(ud24), .set_mode(1'b0),
        .adj_step(1'b0), .load(1'b0), .load_val(5'd0),
        .value(val24), .carry_out(co24), .at_term(at24), .load_err(le24)
    );

    // ---------------- 60 -> 24 cascade ----------------
    logic       rstc = 1'b1;
    logic [5:0] val_lo;
    logic [4:0] val_hi;
    logic       co_lo, at_lo, le_lo, co_hi, at_hi, le_hi;

    mod_time_counter #(.MODULUS(60)) u_lo (
        .clk(clk), .reset_all(rstc), .cnt_en(1'b1), .up_dn(1'b1), .set_mode(1'b0),
        .adj_step(1'b0), .load(1'b0), .load_val(6'd0),
        .value(val_lo), .carry_out(co_lo), .at_term(at_lo), .load_err(le_lo)
    );

    mod_time_counter #(.MODULUS(24)) u_hi (
        .clk(clk), .reset_all(rstc), .cnt_en(co_lo), .up_dn(1'b1), .set_mode(1'b0),
        .adj_step(1'b0), .load(1'b0), .load_val(5'd0),
        .value(val_hi), .carry_out(co_hi), .at_term(at_hi), .load_err(le_hi)
    );

    // ---------------- behavioural model of dut0 ----------------
    int m_val = 0;
    bit m_carry = 0, m_err = 0, m_set = 0, m_adj_prev = 0, m_valid = 0;

    always @(posedge clk) begin
        bit stepping;
        if (rst) begin
            m_val = 0; m_carry = 0; m_err = 0; m_set = 0; m_adj_prev = 0;
            m_valid = 1;
        end else begin
            stepping = m_set ? (adj && !m_adj_prev) : cen;
            m_carry = 0;
            m_err   = 0;
            if (ld) begin
                if (int'(lv) < 60) m_val = int'(lv);
                else m_err = 1;
            end else if (stepping) begin
                if (ud) begin
                    m_carry = !m_set && (m_val == 59);
                    m_val   = (m_val + 1) % 60;
                end else begin
                    m_carry = !m_set && (m_val == 0);
                    m_val   = (m_val + 59) % 60;
                end
            end
            m_set      = sm;
            m_adj_prev = adj;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_value",    32'(val0), 32'(m_val));
            check("model_carry",    32'(co0),  32'(m_carry));
            check("model_load_err", 32'(le0),  32'(m_err));
            check("model_at_term",  32'(at0),  32'(ud ? (m_val == 59) : (m_val == 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int carries;
        tick(); tick();
        check("reset_value",    32'(val0), 0);
        check("reset_carry",    32'(co0),  0);
        check("reset_load_err", 32'(le0),  0);
        check("reset_value24",  32'(val24), 0);

        // First step accepted on the first edge after reset release.
        rst = 0; cen = 1; ud = 1; rst24 = 0;
        tick();
        check("first_step", 32'(val0), 1);
        check("idle24",     32'(val24), 0);

        // Free-running up count: two wraps in 119 further cycles.
        carries = 0;
        for (int i = 0; i < 119; i++) begin
            tick();
            if (co0) carries++;
            if (i == 57) begin
                check("at_term_59", 32'(at0), 1);
                check("no_carry_at_59", 32'(co0), 0);
            end
            if (i == 58) check("carry_after_wrap", 32'(co0), 1);
            if (i == 59) check("carry_one_cycle", 32'(co0), 0);
        end
        check("carry_count_120", 32'(carries), 2);
        check("value_after_120", 32'(val0), 0);
        cen = 0;
        tick();
        check("carry_drops", 32'(co0), 0);

        // Down wrap in RUN with direction changed in the same cycle.
        ud = 0; cen = 1;
        tick();
        check("run_down_wrap_val", 32'(val0), 59);
        check("run_down_wrap_co",  32'(co0),  1);
        cen = 0;
        tick();
        check("run_down_co_clear", 32'(co0), 0);

        // MODULUS=24 stage, single down step from 0.
        ud24 = 0; cen24 = 1;
        tick();
        check("m24_down_val", 32'(val24), 23);
        check("m24_down_co",  32'(co24),  1);
        cen24 = 0;
        tick();
        check("m24_hold_val", 32'(val24), 23);
        check("m24_co_once",  32'(co24),  0);
        check("m24_at_term_down", 32'(at24), 0);
        ud24 = 1;
        #1;
        check("m24_at_term_up", 32'(at24), 1);

        // Load beats a coincident step; out-of-range load is refused.
        ud = 1; ld = 1; lv = 6'd45; cen = 1;
        tick();
        check("load45_val", 32'(val0), 45);
        check("load45_co",  32'(co0),  0);
        check("load45_err", 32'(le0),  0);
        lv = 6'd60;
        tick();
        check("load60_val", 32'(val0), 45);
        check("load60_err", 32'(le0),  1);
        ld = 0; cen = 0;
        tick();
        check("load_err_once", 32'(le0), 0);

        // SET mode: adj_step edges step and wrap silently; cnt_en ignored.
        ld = 1; lv = 6'd59;
        tick();
        ld = 0; sm = 1;
        tick();
        check("set_entry_val", 32'(val0), 59);
        adj = 1; cen = 1;
        tick();
        check("set_wrap_val", 32'(val0), 0);
        check("set_wrap_co",  32'(co0),  0);
        adj = 0;
        tick();
        check("set_cnt_en_ignored", 32'(val0), 0);
        adj = 1;
        tick();
        check("set_step_1", 32'(val0), 1);
        adj = 0;
        tick();
        adj = 1;
        tick();
        check("set_step_2", 32'(val0), 2);
        tick();
        check("set_held_adj", 32'(val0), 2);
        check("set_no_carry", 32'(co0), 0);
        adj = 0; cen = 0; sm = 0;
        tick();

        // Mode changes take effect one cycle after set_mode changes.
        sm = 1; cen = 1;
        tick();
        check("mode_lag_run", 32'(val0), 3);
        tick();
        check("mode_now_set", 32'(val0), 3);
        sm = 0;
        tick();
        check("mode_lag_set", 32'(val0), 3);
        tick();
        check("mode_back_run", 32'(val0), 4);
        cen = 0;

        // Reset at 59 with cnt_en high: no carry on that or the next edge.
        ld = 1; lv = 6'd58; cen = 1;
        tick();
        ld = 0;
        tick();
        check("pre_reset_59", 32'(val0), 59);
        rst = 1;
        tick();
        check("reset_at59_val", 32'(val0), 0);
        check("reset_at59_co",  32'(co0),  0);
        rst = 0; cen = 0;
        tick();
        check("post_reset_val", 32'(val0), 0);
        check("post_reset_co",  32'(co0),  0);

        // Reset mid-SET returns to RUN with a cleared edge register.
        sm = 1;
        tick();
        rst = 1; adj = 1;
        tick();
        rst = 0; sm = 0;
        tick();
        check("reset_mid_set", 32'(val0), 0);
        adj = 0;
        tick();

        // Cascade: hours stage advances once per 60 cycles and wraps after 1440.
        rstc = 0;
        carries = 0;
        for (int k = 1; k <= 1442; k++) begin
            tick();
            check("chain_lo", 32'(val_lo), 32'(k % 60));
            check("chain_hi", 32'(val_hi), 32'(((k - 1) / 60) % 24));
            if (co_hi) carries++;
            if (k == 59)   check("chain_lo_at_term", 32'(at_lo), 1);
            if (k == 60)   check("chain_lo_carry", 32'(co_lo), 1);
            if (k == 61)   check("chain_hi_first", 32'(val_hi), 1);
            if (k == 1440) check("chain_hi_23", 32'(val_hi), 23);
            if (k == 1441) begin
                check("chain_hi_wrap", 32'(val_hi), 0);
                check("chain_hi_carry", 32'(co_hi), 1);
            end
        end
        check("chain_hi_carry_count", 32'(carries), 1);
        check("chain_no_load_err", 32'({le_lo, le_hi, le24}), 0);
        check("chain_hi_at_term", 32'(at_hi), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_time_counter
